// File: rtl/adc_manager_pkg.sv
// Shared definitions for the serial ADC frame manager.
// FSM encodings and default timing parameters live here.
package adc_manager_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_CLK_DIV      = 25;
    localparam int DEF_IDLE_PERIODS = 2;

endpackage

// File: rtl/clk_tick_gen.sv
// Free-running divider producing a one-clk tick every CLK_DIV clks.
// The tick marks each SCLK half-period boundary.
module clk_tick_gen
    import adc_manager_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_manager.sv
// Continuously clocks 8-bit frames out of a serial ADC (SPI mode 0 style)
// and presents each completed byte with a one-clk NEW_BYTE strobe.
module adc_manager
    import adc_manager_pkg::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int IDLE_PERIODS = DEF_IDLE_PERIODS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ADC_read,
    output logic       clk_out,
    output logic       cs_out,
    output logic       out_serial,
    output logic [7:0] out_parallel,
    output logic       NEW_BYTE
);

    localparam int IW = $clog2(2 * IDLE_PERIODS);
    localparam logic [IW-1:0] IDLE_LAST = IW'(2 * IDLE_PERIODS - 1);

    logic tick;

    state_t        state_q, state_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          sclk_q, sclk_d;
    logic          cs_q, cs_d;
    logic          ser_q, ser_d;
    logic [7:0]    par_q, par_d;
    logic          nb_q, nb_d;

    clk_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idle_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            ser_q   <= 1'b0;
            par_q   <= '0;
            nb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            ser_q   <= ser_d;
            par_q   <= par_d;
            nb_q    <= nb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                ST_IDLE:  if (idle_q == IDLE_LAST) state_d = ST_SETUP;
                ST_SETUP: state_d = ST_SHIFT;
                ST_SHIFT: if (sclk_q && bit_q == 3'd7) state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        idle_d  = idle_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        ser_d   = ser_q;
        par_d   = par_q;
        nb_d    = 1'b0;
        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (idle_q == IDLE_LAST) begin
                        idle_d = '0;
                        cs_d   = 1'b0;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end
                ST_SETUP: sclk_d = 1'b0;
                ST_SHIFT: begin
                    sclk_d = ~sclk_q;
                    // sample on the rising edge; bit_q counts completed bits
                    if (!sclk_q) begin
                        shift_d = {shift_q[6:0], ADC_read};
                        ser_d   = ADC_read;
                    end else if (bit_q != 3'd7) begin
                        bit_d = bit_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    par_d = shift_q;
                    nb_d  = 1'b1;
                    cs_d  = 1'b1;
                    bit_d = '0;
                end
                default: ;
            endcase
        end
    end

    assign clk_out      = sclk_q;
    assign cs_out       = cs_q;
    assign out_serial   = ser_q;
    assign out_parallel = par_q;
    assign NEW_BYTE     = nb_q;

endmodule

// File: tb/tb_adc_manager.sv
// Self-checking bench: an ADC model feeds queued bytes, a scoreboard
// compares every completed byte, frame timing and SCLK/CS relations.
module tb_adc_manager;
    import adc_manager_pkg::*;

    localparam int CLK_DIV      = DEF_CLK_DIV;
    localparam int IDLE_PERIODS = DEF_IDLE_PERIODS;
    localparam int IDLE_CLKS    = 2 * IDLE_PERIODS * CLK_DIV;
    localparam int FRAME_CLKS   = (2 * IDLE_PERIODS + 18) * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ADC_read = 1'b0;
    logic       clk_out;
    logic       cs_out;
    logic       out_serial;
    logic [7:0] out_parallel;
    logic       NEW_BYTE;

    adc_manager #(
        .CLK_DIV     (CLK_DIV),
        .IDLE_PERIODS(IDLE_PERIODS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ADC_read    (ADC_read),
        .clk_out     (clk_out),
        .cs_out      (cs_out),
        .out_serial  (out_serial),
        .out_parallel(out_parallel),
        .NEW_BYTE    (NEW_BYTE)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    int         nb_cnt = 0;
    int         rises = 0;
    int         cyc = 0;
    int         last_nb = -1;
    logic       p_cs = 1'b1;
    logic       p_sclk = 1'b0;
    logic       p_nb = 1'b0;
    logic [7:0] cur = 8'h00;
    logic [7:0] e;
    int         idx = 8;

    // ADC model and scoreboard, evaluated away from the active edge
    initial begin : mon
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                exp_q.delete();
                rises   = 0;
                last_nb = -1;
                idx     = 8;
            end else begin
                if (p_cs && !cs_out) begin
                    check("cs_fall_sclk", 32'(clk_out), 32'(0));
                    cur = (tx_q.size() != 0) ? tx_q.pop_front() : 8'($urandom);
                    exp_q.push_back(cur);
                    idx      = 0;
                    rises    = 0;
                    ADC_read = cur[7];
                end else if (!p_cs && cs_out) begin
                    check("cs_rise_sclk", 32'(clk_out), 32'(0));
                    check("rises", rises, 8);
                    rises = 0;
                end
                if (!cs_out && clk_out && !p_sclk) begin
                    rises++;
                    check("serial", 32'(out_serial), 32'(cur[7-idx]));
                end
                if (!cs_out && !clk_out && p_sclk) begin
                    idx++;
                    if (idx < 8) ADC_read = cur[7-idx];
                end
                if (cs_out) ADC_read = 1'($urandom);
                if (NEW_BYTE) begin
                    check("nb_width", 32'(p_nb), 32'(0));
                    if (exp_q.size() == 0) begin
                        check("nb_unexpected", 32'(1), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", 32'(out_parallel), 32'(e));
                        if (e == 8'hA5) check("serial_a5", 32'(out_serial), 32'(1));
                    end
                    if (last_nb >= 0) check("nb_gap", cyc - last_nb, FRAME_CLKS);
                    last_nb = cyc;
                    nb_cnt++;
                end
            end
            p_cs   = cs_out;
            p_sclk = clk_out;
            p_nb   = NEW_BYTE;
        end
    end

    task automatic wait_cs_fall(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (cs_out && n < 5000);
    endtask

    task automatic wait_nb(input int target, input int budget);
        int n;
        n = 0;
        while (nb_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (nb_cnt < target) check("nb_timeout", nb_cnt, target);
    endtask

    initial begin : main
        int n;
        int base;
        tx_q = '{8'hA5, 8'hFF, 8'h00, 8'($urandom_range(1, 255))};

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", 32'(clk_out), 32'(0));
        check("rst_cs", 32'(cs_out), 32'(1));
        check("rst_par", 32'(out_parallel), 32'(0));
        check("rst_nb", 32'(NEW_BYTE), 32'(0));
        check("rst_ser", 32'(out_serial), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        wait_cs_fall(n);
        check("cs_fall_lat", n, IDLE_CLKS);

        wait_nb(4, 5 * FRAME_CLKS);

        // abort the next frame after its 4th SCLK rising edge
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(rises == 4 && !cs_out) && n < 2 * FRAME_CLKS);
        if (n >= 2 * FRAME_CLKS) check("rise4_timeout", 32'(0), 32'(1));
        rst = 1'b0;
        #1;
        check("abort_cs", 32'(cs_out), 32'(1));
        check("abort_sclk", 32'(clk_out), 32'(0));
        check("abort_par", 32'(out_parallel), 32'(0));
        check("abort_nb", 32'(NEW_BYTE), 32'(0));
        tx_q.push_front(8'h3C);
        base = nb_cnt;
        repeat (3) @(posedge clk);
        #1;
        check("abort_hold_nb", nb_cnt - base, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_cs_fall(n);
        check("cs_fall_lat2", n, IDLE_CLKS);
        wait_nb(base + 1, 2 * FRAME_CLKS);
        #1;
        check("byte_3c", 32'(out_parallel), 32'(8'h3C));

        for (int i = 0; i < 16; i++) tx_q.push_back(8'($urandom));
        base = nb_cnt;
        wait_nb(base + 16, 18 * FRAME_CLKS);
        check("nb_total", nb_cnt - base, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_manager.md
ADC_MANAGER -- requirements
Module: ADC_manager

Interface
REQ-001 Parameter CLK_DIV, default 25: system clocks per SCLK half-period (25 at 50 MHz gives a 1 MHz clk_out); legal range >=2.
REQ-002 Parameter IDLE_PERIODS, default 2: full SCLK periods cs_out stays high between frames; legal range >=1.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 ADC_read  input  1  serial data from the ADC (MISO); ADC changes it on falling clk_out, MSB first.
REQ-006 clk_out  output  1  serial clock to the ADC (SCLK); idle low.
REQ-007 cs_out  output  1  ADC chip select, active-low.
REQ-008 out_serial  output  1  most recently sampled ADC_read bit.
REQ-009 out_parallel  output  8  last completed byte, MSB = first bit received.
REQ-010 NEW_BYTE  output  1  one-clk pulse when out_parallel is updated.

Function
REQ-011 Free-running half-period tick: counter 0..CLK_DIV-1; tick asserted for one clk when counter = CLK_DIV-1, then counter wraps to 0.
REQ-012 All state changes other than NEW_BYTE clearing occur only on tick cycles.
REQ-013 FSM states: IDLE, SETUP, SHIFT, DONE; conversions repeat continuously with no start input.
REQ-014 IDLE: cs_out=1, clk_out=0; after 2*IDLE_PERIODS ticks go to SETUP.
REQ-015 SETUP: cs_out driven low at entry; clk_out held low for one tick (half-period setup); then go to SHIFT.
REQ-016 SHIFT: clk_out toggles on every tick, 8 rising and 8 falling edges (16 ticks).
REQ-017 On each tick that drives clk_out 0->1, ADC_read is captured: shift register <= {shift[6:0], ADC_read}; out_serial <= ADC_read.
REQ-018 Bit counter 0..7 increments per rising edge; after the 8th falling edge go to DONE with clk_out=0.
REQ-019 DONE (one tick): out_parallel <= shift register, NEW_BYTE=1 for exactly one clk, cs_out <= 1, bit counter cleared, go to IDLE.
REQ-020 out_parallel holds its value between frames; changes only in DONE.
REQ-021 Frame period = (2*IDLE_PERIODS + 18) ticks of CLK_DIV clks; at defaults 22*25 = 550 clks per byte.
REQ-022 cs_out never falls while clk_out is high; clk_out never toggles while cs_out is high.

Reset
REQ-023 While rst=0, asynchronously: state=IDLE, tick counter=0, idle counter=0, bit counter=0, shift register=0, clk_out=0, cs_out=1, out_serial=0, out_parallel=8'h00, NEW_BYTE=0.
REQ-024 Reset mid-frame aborts the frame: no NEW_BYTE, out_parallel=0; after release, full IDLE interval precedes the next cs_out fall.

Structure
REQ-025 FSM state encodings and default CLK_DIV/IDLE_PERIODS belong in a shared package (adc_manager_pkg).
REQ-026 One natural sub-module: clk_tick_gen (parameterized half-period tick divider); everything else is inline.

Verification
REQ-027 Assert rst=0 for 3 clks, release -> clk_out=0, cs_out=1, out_parallel=0x00, NEW_BYTE=0; first cs_out fall exactly 2*IDLE_PERIODS*CLK_DIV clks after release.
REQ-028 Bench drives ADC_read from bit vector on each falling clk_out, bits 1,0,1,0,0,1,0,1 -> out_parallel=0xA5, one single-clk NEW_BYTE pulse, out_serial=1.
REQ-029 Back-to-back bytes 0xFF then 0x00 -> NEW_BYTE pulses exactly 550 clks apart (defaults), out_parallel 0xFF then 0x00.
REQ-030 Count clk_out rising edges per cs_out low window -> exactly 8; clk_out low at every cs_out edge.
REQ-031 Pulse rst low after 4th rising clk_out -> cs_out=1 immediately, out_parallel=0x00, no NEW_BYTE; next frame of 0x3C yields out_parallel=0x3C.
REQ-032 128-bit stimulus vector (16 bytes) run for 12.5 ms -> 16 NEW_BYTE pulses, out_parallel matches each byte in order.
